// File: rtl/spi_reg_pkg.sv
// Shared frame layout, register map and FSM state type for the SPI register controller.
package spi_reg_pkg;

    localparam int unsigned RW_BIT   = 15;
    localparam int unsigned ADDR_MSB = 14;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;

    localparam int unsigned ADDR_EN_OUT_LO = 0;
    localparam int unsigned ADDR_EN_OUT_HI = 1;
    localparam int unsigned ADDR_EN_PWM_LO = 2;
    localparam int unsigned ADDR_EN_PWM_HI = 3;
    localparam int unsigned ADDR_PWM_DUTY  = 4;
    localparam int unsigned NUM_REGS       = 5;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StErr
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is the SPI receiver, bit 1 the host port.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    // Requester that won the most recent handshake (1 = host).
    logic last_q, last_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (accept_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Arbitrates SPI/host write frames and commits them into the PWM configuration registers.
// Optional build macro SHADOW_COMMIT_EN stages writes in shadows until a COMMIT_ADDR write.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int unsigned MAX_ADDR    = 4,
    parameter int unsigned ERR_W       = 8,
    parameter logic [6:0]  COMMIT_ADDR = 7'h7F
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             spi_valid_i,
    input  logic [15:0]      spi_data_i,
    output logic             spi_ready_o,
    input  logic             host_valid_i,
    input  logic [15:0]      host_data_i,
    output logic             host_ready_o,
    output logic [7:0]       en_reg_out_7_0_o,
    output logic [7:0]       en_reg_out_15_8_o,
    output logic [7:0]       en_reg_pwm_7_0_o,
    output logic [7:0]       en_reg_pwm_15_8_o,
    output logic [7:0]       pwm_duty_cycle_o,
    output logic             wr_err_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic             busy_o
);

    state_e           state_q, state_d;
    logic [15:0]      hold_q, hold_d;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       regs_d [NUM_REGS];
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [1:0]       req, gnt;
    logic             accept;
    logic             is_wr;
    logic [6:0]       addr;
    logic [7:0]       data;
    logic             in_range;
    logic             has_reg;

`ifdef SHADOW_COMMIT_EN
    logic [7:0]       shadow_q [NUM_REGS];
    logic [7:0]       shadow_d [NUM_REGS];
`endif

    // Requests are only presented while idle, so both readys drop everywhere else.
    assign req = {host_valid_i, spi_valid_i} & {2{state_q == StIdle}};

    rr_arb2 u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    assign accept       = gnt != 2'b00;
    assign spi_ready_o  = gnt[0];
    assign host_ready_o = gnt[1];

    assign is_wr    = hold_q[RW_BIT];
    assign addr     = hold_q[ADDR_MSB:ADDR_LSB];
    assign data     = hold_q[DATA_MSB:DATA_LSB];
    assign in_range = 32'(addr) <= MAX_ADDR;
    assign has_reg  = 32'(addr) < NUM_REGS;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        regs_d    = regs_q;
        err_cnt_d = err_cnt_q;
`ifdef SHADOW_COMMIT_EN
        shadow_d  = shadow_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    hold_d  = gnt[0] ? spi_data_i : host_data_i;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                state_d = StIdle;
                if (is_wr) begin
`ifdef SHADOW_COMMIT_EN
                    if (addr == COMMIT_ADDR) begin
                        regs_d = shadow_q;
                    end else if (in_range) begin
                        if (has_reg) shadow_d[addr[2:0]] = data;
                    end else begin
                        state_d = StErr;
                    end
`else
                    if (in_range && (addr != COMMIT_ADDR)) begin
                        if (has_reg) regs_d[addr[2:0]] = data;
                    end else begin
                        state_d = StErr;
                    end
`endif
                end
            end
            StErr: begin
                state_d = StIdle;
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            regs_q    <= '{default: '0};
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            regs_q    <= regs_d;
            err_cnt_q <= err_cnt_d;
        end
    end

`ifdef SHADOW_COMMIT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= '{default: '0};
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

    assign en_reg_out_7_0_o  = regs_q[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8_o = regs_q[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0_o  = regs_q[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8_o = regs_q[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle_o  = regs_q[ADDR_PWM_DUTY];
    assign wr_err_o          = state_q == StErr;
    assign err_count_o       = err_cnt_q;
    assign busy_o            = state_q != StIdle;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed self-checking bench for spi_reg_ctrl; honours SHADOW_COMMIT_EN when defined.
module tb_spi_reg_ctrl;

`ifdef SHADOW_COMMIT_EN
    localparam bit Shadow = 1'b1;
`else
    localparam bit Shadow = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_valid = 1'b0;
    logic [15:0] spi_data = '0;
    logic        spi_ready;
    logic        host_valid = 1'b0;
    logic [15:0] host_data = '0;
    logic        host_ready;
    logic [7:0]  out_lo, out_hi, pwm_lo, pwm_hi, duty;
    logic        wr_err;
    logic [7:0]  err_count;
    logic        busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    spi_reg_ctrl dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .spi_valid_i       (spi_valid),
        .spi_data_i        (spi_data),
        .spi_ready_o       (spi_ready),
        .host_valid_i      (host_valid),
        .host_data_i       (host_data),
        .host_ready_o      (host_ready),
        .en_reg_out_7_0_o  (out_lo),
        .en_reg_out_15_8_o (out_hi),
        .en_reg_pwm_7_0_o  (pwm_lo),
        .en_reg_pwm_15_8_o (pwm_hi),
        .pwm_duty_cycle_o  (duty),
        .wr_err_o          (wr_err),
        .err_count_o       (err_count),
        .busy_o            (busy)
    );

    // Presents one frame and returns #1 after the handshake edge.
    task automatic send(input bit use_host, input logic [15:0] frame, output bit ok);
        ok = 1'b0;
        if (use_host) begin
            host_valid = 1'b1;
            host_data  = frame;
        end else begin
            spi_valid = 1'b1;
            spi_data  = frame;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (use_host ? host_ready : spi_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        spi_valid  = 1'b0;
        host_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++; if ({out_lo, out_hi, pwm_lo, pwm_hi, duty} !== 40'h0) $display("FAIL reset_regs: got %h want 0", {out_lo, out_hi, pwm_lo, pwm_hi, duty}); else pass_cnt++;
        chk_cnt++; if (err_count !== 8'h00) $display("FAIL reset_errcnt: got %h want 00", err_count); else pass_cnt++;
        chk_cnt++; if (wr_err !== 1'b0) $display("FAIL reset_wr_err: got %b want 0", wr_err); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if ({spi_ready, host_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {spi_ready, host_ready}); else pass_cnt++;
    endtask

    task automatic test_write();
        bit ok;
        send(1'b0, 16'h80F0, ok);
        chk_cnt++; if (!ok) $display("FAIL write_handshake: got timeout want ready"); else pass_cnt++;
        chk_cnt++; if ({busy, spi_ready, wr_err} !== 3'b100) $display("FAIL write_check_state: got %b want 100", {busy, spi_ready, wr_err}); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if (out_lo !== (Shadow ? 8'h00 : 8'hF0)) $display("FAIL write_out_lo: got %h want %h", out_lo, Shadow ? 8'h00 : 8'hF0); else pass_cnt++;
        chk_cnt++; if ({out_hi, pwm_lo, pwm_hi, duty} !== 32'h0) $display("FAIL write_others: got %h want 0", {out_hi, pwm_lo, pwm_hi, duty}); else pass_cnt++;
        chk_cnt++; if ({busy, wr_err} !== 2'b00) $display("FAIL write_idle: got %b want 00", {busy, wr_err}); else pass_cnt++;
    endtask

    task automatic test_arbitration();
        do_reset();
        spi_valid  = 1'b1; spi_data  = 16'h8411;
        host_valid = 1'b1; host_data = 16'h8422;
        @(negedge clk);
        chk_cnt++; if ({spi_ready, host_ready} !== 2'b10) $display("FAIL arb_first: got %b want 10", {spi_ready, host_ready}); else pass_cnt++;
        @(posedge clk); #1;
        spi_valid = 1'b0;
        chk_cnt++; if ({busy, spi_ready, host_ready} !== 3'b100) $display("FAIL arb_busy: got %b want 100", {busy, spi_ready, host_ready}); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if (duty !== (Shadow ? 8'h00 : 8'h11)) $display("FAIL arb_duty_spi: got %h want %h", duty, Shadow ? 8'h00 : 8'h11); else pass_cnt++;
        chk_cnt++; if ({spi_ready, host_ready} !== 2'b01) $display("FAIL arb_second: got %b want 01", {spi_ready, host_ready}); else pass_cnt++;
        @(posedge clk); #1;
        host_valid = 1'b0;
        @(posedge clk); #1;
        chk_cnt++; if (duty !== (Shadow ? 8'h00 : 8'h22)) $display("FAIL arb_duty_host: got %h want %h", duty, Shadow ? 8'h00 : 8'h22); else pass_cnt++;
    endtask

    task automatic test_error();
        bit ok;
        send(1'b0, 16'h85AA, ok);
        chk_cnt++; if (!ok || wr_err !== 1'b0) $display("FAIL err_handshake: got ok=%b wr_err=%b want ok=1 wr_err=0", ok, wr_err); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if ({wr_err, busy, err_count} !== {2'b11, 8'h00}) $display("FAIL err_pulse: got %b%b cnt=%h want 11 cnt=00", wr_err, busy, err_count); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if ({wr_err, busy, err_count} !== {2'b00, 8'h01}) $display("FAIL err_count1: got %b%b cnt=%h want 00 cnt=01", wr_err, busy, err_count); else pass_cnt++;
        chk_cnt++; if ({out_lo, pwm_lo, duty} !== {16'h0, Shadow ? 8'h00 : 8'h22}) $display("FAIL err_regs_hold: got %h", {out_lo, pwm_lo, duty}); else pass_cnt++;
        spi_valid = 1'b1;
        spi_data  = 16'h85AA;
        repeat (905) @(posedge clk);
        #1;
        spi_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk_cnt++; if (err_count !== 8'hFF) $display("FAIL err_saturate: got %h want FF", err_count); else pass_cnt++;
    endtask

    task automatic test_read();
        bit ok;
        send(1'b0, 16'h0255, ok);
        chk_cnt++; if (!ok || busy !== 1'b1) $display("FAIL read_handshake: got ok=%b busy=%b want 1 1", ok, busy); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if ({busy, wr_err, pwm_lo, err_count} !== {2'b00, 8'h00, 8'hFF}) $display("FAIL read_noop: got busy=%b err=%b pwm_lo=%h cnt=%h", busy, wr_err, pwm_lo, err_count); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        send(1'b0, 16'h8377, ok);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_cnt++; if ({pwm_hi, duty, err_count, busy} !== 25'h0) $display("FAIL rstmid_state: got pwm_hi=%h duty=%h cnt=%h busy=%b", pwm_hi, duty, err_count, busy); else pass_cnt++;
        spi_valid  = 1'b1; spi_data  = 16'h8111;
        host_valid = 1'b1; host_data = 16'h8122;
        @(negedge clk);
        chk_cnt++; if ({spi_ready, host_ready} !== 2'b10) $display("FAIL rstmid_grant: got %b want 10", {spi_ready, host_ready}); else pass_cnt++;
        @(posedge clk); #1;
        spi_valid = 1'b0;
        @(posedge clk); #1;
        chk_cnt++; if (out_hi !== (Shadow ? 8'h00 : 8'h11)) $display("FAIL rstmid_spi_write: got %h want %h", out_hi, Shadow ? 8'h00 : 8'h11); else pass_cnt++;
        @(posedge clk); #1;
        host_valid = 1'b0;
        @(posedge clk); #1;
        chk_cnt++; if (out_hi !== (Shadow ? 8'h00 : 8'h22)) $display("FAIL rstmid_host_write: got %h want %h", out_hi, Shadow ? 8'h00 : 8'h22); else pass_cnt++;
    endtask

    task automatic test_commit();
        bit ok;
        send(1'b1, 16'h823C, ok);
        @(posedge clk); #1;
        chk_cnt++; if (pwm_lo !== (Shadow ? 8'h00 : 8'h3C)) $display("FAIL commit_staged: got %h want %h", pwm_lo, Shadow ? 8'h00 : 8'h3C); else pass_cnt++;
        send(1'b0, 16'hFF00, ok);
        @(posedge clk); #1;
        chk_cnt++; if (wr_err !== !Shadow) $display("FAIL commit_wr_err: got %b want %b", wr_err, !Shadow); else pass_cnt++;
        chk_cnt++; if ({out_hi, pwm_lo} !== 16'h223C) $display("FAIL commit_outputs: got %h want 223C", {out_hi, pwm_lo}); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if (err_count !== (Shadow ? 8'h00 : 8'h01)) $display("FAIL commit_errcnt: got %h want %h", err_count, Shadow ? 8'h00 : 8'h01); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_arbitration();
        test_error();
        test_read();
        test_reset_mid_frame();
        test_commit();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
